// File: rtl/cvxif_instr_pkg.sv
// Shared constants for the coprocessor instruction/result path.
// Holds the default result-buffer depth and the register-index width.
package cvxif_instr_pkg;

    localparam int COPRO_RESULT_DEPTH = 4;
    localparam int COPRO_RD_W         = 5;

endpackage

// File: rtl/copro_result_fifo.sv
// Generic circular FIFO: storage, wrap-around pointers, occupancy count, full/empty.
// Push and pop are accepted when space/data allow; a push while full succeeds only alongside a pop.
module copro_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr];
    assign count = count_q;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/copro_result_buffer.sv
// Result buffer between the non-stallable coprocessor ALU and the CV-X-IF result port.
// Queues results, replays them under valid/ready, and issues credits so pushes never find it full.
import cvxif_instr_pkg::*;

module copro_result_buffer #(
    parameter int  XLEN     = 32,
    parameter int  DEPTH    = COPRO_RESULT_DEPTH,
    parameter type hartid_t = logic,
    parameter type id_t     = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_fire_i,
    output logic                   issue_ready_o,
    input  logic                   alu_valid_i,
    input  logic [XLEN-1:0]        alu_result_i,
    input  hartid_t                alu_hartid_i,
    input  id_t                    alu_id_i,
    input  logic [COPRO_RD_W-1:0]  alu_rd_i,
    input  logic                   alu_we_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [XLEN-1:0]        result_data_o,
    output hartid_t                result_hartid_o,
    output id_t                    result_id_o,
    output logic [COPRO_RD_W-1:0]  result_rd_o,
    output logic                   result_we_o,
    output logic                   overflow_o
);
    localparam int CW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]       result;
        hartid_t               hartid;
        id_t                   id;
        logic [COPRO_RD_W-1:0] rd;
        logic                  we;
    } entry_t;

    entry_t        push_entry;
    entry_t        head_entry;
    logic [CW:0]   count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          pending_q;
    logic          overflow_q;
    logic [CW+1:0] credit_sum;

    // Handshake: an entry transfers on a cycle where result_valid_o && result_ready_i;
    // while valid is high and ready low, every result_*_o holds its value.
    assign pop = result_valid_o && result_ready_i;

    assign push_entry = '{result: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                          rd: alu_rd_i, we: alu_we_i};

    copro_result_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (alu_valid_i),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Credit counts stored entries plus the one result still inside the ALU; it
    // depends only on registers, so result_ready_i never reaches issue_ready_o.
    always_comb begin
        credit_sum    = (CW+2)'(count) + (CW+2)'(pending_q);
        issue_ready_o = credit_sum < (CW+2)'(DEPTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= issue_fire_i && issue_ready_o;
            if (alu_valid_i && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign result_valid_o  = !empty;
    assign result_data_o   = head_entry.result;
    assign result_hartid_o = head_entry.hartid;
    assign result_id_o     = head_entry.id;
    assign result_rd_o     = head_entry.rd;
    assign result_we_o     = head_entry.we;
    assign overflow_o      = overflow_q;

endmodule
